mdu_issue_ctrl: RTL and testbench

- Issue controller in E stage for the multiply/divide unit.
- Accepts one MDU-class request per cycle from the pipeline and drives the MDU's Start/MDUOp.
- Tracks the multi-cycle latency with its own counter, gates mfhi/mflo reads, and produces the pipeline stall.
- Also flags divide-by-zero and counts stall cycles for performance debug.

---
 rtl/mdu_issue_ctrl.sv | 119 +++++++++++
 tb/tb_mdu_issue_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue_ctrl.sv
// Issue controller for the multiply/divide unit in the E stage.
// Grants one MDU-class request per cycle and drives Start/MDUOp to the MDU.
// Tracks the multi-cycle latency and stalls the pipeline while the MDU is busy.
// Also gates HI/LO reads, flags divide-by-zero and counts stall cycles.
module mdu_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic        req_d2_zero,
  input  logic        flush,
  output logic        req_ready,
  output logic        stall,
  output logic        mdu_start,
  output logic [3:0]  mdu_op,
  output logic        rd_valid,
  output logic        rd_sel,
  output logic        busy,
  output logic        div0,
  output logic [31:0] stall_cnt
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      stall_cnt_q;

  logic op_valid, op_long, op_write, op_read, op_div;
  logic live_req, grant;

  // Decode the request class and the grant/stall qualifiers.
  always_comb begin
    op_valid = (req_op >= 4'd1) && (req_op <= 4'd10);
    op_long  = (req_op == 4'd1) || (req_op == 4'd2) || (req_op == 4'd3) ||
               (req_op == 4'd4) || (req_op == 4'd9) || (req_op == 4'd10);
    op_write = (req_op == 4'd7) || (req_op == 4'd8);
    op_read  = (req_op == 4'd5) || (req_op == 4'd6);
    op_div   = (req_op == 4'd3) || (req_op == 4'd4);
    live_req = req_valid && !flush && op_valid;
    grant    = live_req && (state_q == IDLE);
  end

  // State and latency counter; an async reset abandons any op in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and MDU/pipeline-facing outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = (state_q == IDLE);
    stall     = live_req && (state_q == RUN);
    mdu_start = 1'b0;
    mdu_op    = 4'd0;
    rd_valid  = 1'b0;
    rd_sel    = 1'b0;
    div0      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          if (op_long) begin
            mdu_start = 1'b1;
            mdu_op    = req_op;
            div0      = op_div && req_d2_zero;
            state_d   = RUN;
            cnt_d     = op_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          end else if (op_write) begin
            mdu_op = req_op;
          end else if (op_read) begin
            rd_valid = 1'b1;
            rd_sel   = (req_op == 4'd6);
          end
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy = mdu_start || (state_q == RUN);
  end

  // Saturating stall-cycle counter for performance debug.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: one task per scenario, inline checks.
module tb_mdu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_op = 4'd0;
  logic        req_d2_zero = 1'b0;
  logic        flush = 1'b0;
  logic        req_ready, stall, mdu_start, rd_valid, rd_sel, busy, div0;
  logic [3:0]  mdu_op;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_issue_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_d2_zero(req_d2_zero), .flush(flush), .req_ready(req_ready),
    .stall(stall), .mdu_start(mdu_start), .mdu_op(mdu_op),
    .rd_valid(rd_valid), .rd_sel(rd_sel), .busy(busy), .div0(div0),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Apply inputs on the falling edge, then settle 1 time unit before checking.
  task automatic drive(input logic v, input logic [3:0] op, input logic z, input logic f);
    @(negedge clk);
    req_valid = v; req_op = op; req_d2_zero = z; flush = f;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_valid = 0; req_op = 0; req_d2_zero = 0; flush = 0;
    reset = 1; #2; reset = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %0b want 1", req_ready); end
    n_checks++; if ({stall, mdu_start, mdu_op, rd_valid, rd_sel, busy, div0} !== 10'd0) begin
      n_fail++; $display("FAIL reset_outputs got %b want 0", {stall, mdu_start, mdu_op, rd_valid, rd_sel, busy, div0}); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    reset = 0;
  endtask

  task automatic test_mult_then_mfhi();
    do_reset();
    drive(1, 4'd1, 0, 0);
    n_checks++; if ({mdu_start, mdu_op, busy, stall} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL mult_c0 got start=%0b op=%0d busy=%0b stall=%0b want 1 1 1 0", mdu_start, mdu_op, busy, stall); end
    for (int c = 1; c <= 5; c++) begin
      drive(1, 4'd5, 0, 0);
      n_checks++; if ({stall, busy, mdu_start, mdu_op, rd_valid, req_ready} !== {1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL mult_run_c%0d got stall=%0b busy=%0b start=%0b op=%0d rdv=%0b rdy=%0b want 1 1 0 0 0 0",
                           c, stall, busy, mdu_start, mdu_op, rd_valid, req_ready); end
    end
    drive(1, 4'd5, 0, 0);
    n_checks++; if ({rd_valid, rd_sel, stall, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL mfhi_c6 got rdv=%0b sel=%0b stall=%0b busy=%0b want 1 0 0 0", rd_valid, rd_sel, stall, busy); end
    n_checks++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL mult_stall_cnt got %0d want 5", stall_cnt); end
    drive(0, 4'd0, 0, 0);
  endtask

  task automatic test_div_zero_back_to_back();
    do_reset();
    drive(1, 4'd3, 1, 0);
    n_checks++; if ({div0, mdu_start, mdu_op} !== {1'b1, 1'b1, 4'd3}) begin
      n_fail++; $display("FAIL div0_c0 got div0=%0b start=%0b op=%0d want 1 1 3", div0, mdu_start, mdu_op); end
    for (int c = 1; c <= 10; c++) begin
      drive(1, 4'd3, 0, 0);
      n_checks++; if ({stall, busy, mdu_start, div0} !== 4'b1100) begin
        n_fail++; $display("FAIL div_run_c%0d got stall=%0b busy=%0b start=%0b div0=%0b want 1 1 0 0", c, stall, busy, mdu_start, div0); end
    end
    drive(1, 4'd3, 0, 0);
    n_checks++; if ({mdu_start, mdu_op, stall, div0} !== {1'b1, 4'd3, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL div_b2b_c11 got start=%0b op=%0d stall=%0b div0=%0b want 1 3 0 0", mdu_start, mdu_op, stall, div0); end
    n_checks++; if (stall_cnt !== 32'd10) begin n_fail++; $display("FAIL div_stall_cnt got %0d want 10", stall_cnt); end
    drive(0, 4'd0, 0, 0);
  endtask

  task automatic test_write_read();
    do_reset();
    drive(1, 4'd7, 0, 0);
    n_checks++; if ({mdu_op, mdu_start, busy, stall, rd_valid} !== {4'd7, 4'b0000}) begin
      n_fail++; $display("FAIL mthi got op=%0d start=%0b busy=%0b stall=%0b rdv=%0b want 7 0 0 0 0", mdu_op, mdu_start, busy, stall, rd_valid); end
    drive(1, 4'd8, 0, 0);
    n_checks++; if ({mdu_op, mdu_start, busy, stall, req_ready} !== {4'd8, 4'b0001}) begin
      n_fail++; $display("FAIL mtlo got op=%0d start=%0b busy=%0b stall=%0b rdy=%0b want 8 0 0 0 1", mdu_op, mdu_start, busy, stall, req_ready); end
    drive(1, 4'd6, 0, 0);
    n_checks++; if ({rd_valid, rd_sel, mdu_op, mdu_start, busy, stall} !== {2'b11, 4'd0, 3'b000}) begin
      n_fail++; $display("FAIL mflo got rdv=%0b sel=%0b op=%0d start=%0b busy=%0b stall=%0b want 1 1 0 0 0 0",
                         rd_valid, rd_sel, mdu_op, mdu_start, busy, stall); end
    drive(0, 4'd0, 0, 0);
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL wr_stall_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_invalid_op();
    do_reset();
    drive(1, 4'd11, 0, 0);
    n_checks++; if ({mdu_start, mdu_op, rd_valid, busy} !== 7'd0) begin
      n_fail++; $display("FAIL op11_idle got start=%0b op=%0d rdv=%0b busy=%0b want 0", mdu_start, mdu_op, rd_valid, busy); end
    drive(1, 4'd2, 0, 0);
    drive(1, 4'd0, 0, 0);
    n_checks++; if ({stall, busy} !== 2'b01) begin
      n_fail++; $display("FAIL op0_run got stall=%0b busy=%0b want 0 1", stall, busy); end
    drive(1, 4'd15, 0, 0);
    n_checks++; if ({stall, busy} !== 2'b01) begin
      n_fail++; $display("FAIL op15_run got stall=%0b busy=%0b want 0 1", stall, busy); end
    for (int c = 0; c < 4; c++) drive(0, 4'd0, 0, 0);
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 4'd9, 0, 1);
    n_checks++; if ({mdu_start, mdu_op, busy, req_ready} !== {1'b0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL flush_grant got start=%0b op=%0d busy=%0b rdy=%0b want 0 0 0 1", mdu_start, mdu_op, busy, req_ready); end
    drive(0, 4'd0, 0, 0);
    n_checks++; if ({busy, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL flush_idle got busy=%0b rdy=%0b want 0 1", busy, req_ready); end
    drive(1, 4'd1, 0, 0);
    for (int c = 1; c <= 5; c++) begin
      drive(1, 4'd5, 0, (c == 3));
      n_checks++; if ({stall, busy} !== {(c != 3), 1'b1}) begin
        n_fail++; $display("FAIL flush_run_c%0d got stall=%0b busy=%0b want %0b 1", c, stall, busy, (c != 3)); end
    end
    drive(1, 4'd5, 0, 0);
    n_checks++; if ({rd_valid, busy, stall} !== 3'b100) begin
      n_fail++; $display("FAIL flush_done got rdv=%0b busy=%0b stall=%0b want 1 0 0", rd_valid, busy, stall); end
    n_checks++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL flush_stall_cnt got %0d want 4", stall_cnt); end
    drive(0, 4'd0, 0, 0);
  endtask

  task automatic test_async_reset_mid_run();
    do_reset();
    drive(1, 4'd1, 0, 0);
    drive(1, 4'd5, 0, 0);
    drive(1, 4'd5, 0, 0);
    drive(1, 4'd5, 0, 0);
    n_checks++; if ({stall, busy, dut.cnt_q} !== {2'b11, 4'd3}) begin
      n_fail++; $display("FAIL pre_reset got stall=%0b busy=%0b cnt=%0d want 1 1 3", stall, busy, dut.cnt_q); end
    #2 reset = 1;
    #1;
    n_checks++; if ({busy, stall, mdu_start, req_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL async_reset got busy=%0b stall=%0b start=%0b rdy=%0b want 0 0 0 1", busy, stall, mdu_start, req_ready); end
    n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL async_reset_cnt got %0d want 0", stall_cnt); end
    @(negedge clk);
    reset = 0;
    drive(1, 4'd1, 0, 0);
    n_checks++; if ({mdu_start, mdu_op, busy} !== {1'b1, 4'd1, 1'b1}) begin
      n_fail++; $display("FAIL post_reset_mult got start=%0b op=%0d busy=%0b want 1 1 1", mdu_start, mdu_op, busy); end
    for (int c = 0; c < 6; c++) drive(0, 4'd0, 0, 0);
  endtask

  task automatic test_stall_cnt_saturate();
    do_reset();
    drive(1, 4'd3, 0, 0);
    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFD;
    #1 release dut.stall_cnt_q;
    req_valid = 1; req_op = 4'd3; req_d2_zero = 0; flush = 0;
    #1;
    n_checks++; if (stall_cnt !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sat_preset got %h want fffffffd", stall_cnt); end
    drive(1, 4'd3, 0, 0);
    n_checks++; if (stall_cnt !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_step1 got %h want fffffffe", stall_cnt); end
    drive(1, 4'd3, 0, 0);
    n_checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_step2 got %h want ffffffff", stall_cnt); end
    drive(1, 4'd3, 0, 0);
    drive(1, 4'd3, 0, 0);
    n_checks++; if (stall_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold got %h want ffffffff", stall_cnt); end
    drive(0, 4'd0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_mult_then_mfhi();
    test_div_zero_back_to_back();
    test_write_read();
    test_invalid_op();
    test_flush();
    test_async_reset_mid_run();
    test_stall_cnt_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
